// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per amount bit (MSB stage first), valid/ready flow control.
// Optional sticky path enabled by defining PIPE_BARREL_SHIFTER_STICKY_EN.
module pipe_barrel_shifter #(
    parameter int WIDTH = 25,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    localparam logic [SHW:0] AMT_WRAP = (SHW+1)'(WIDTH);

    if (WIDTH < 2 || SHW != $clog2(WIDTH)) begin : g_param_check
        $error("pipe_barrel_shifter: requires WIDTH >= 2 and SHW == $clog2(WIDTH)");
    end

    // Every stage shift is below WIDTH because 2^(SHW-1) < WIDTH, so rotate never wraps twice.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       mode,
                                                  input int unsigned      sh);
        logic signed [WIDTH-1:0] sd;
        sd = d;
        case (mode)
            MODE_SLL: shift_by = d << sh;
            MODE_SRL: shift_by = d >> sh;
            MODE_SRA: shift_by = sd >>> sh;
            default:  shift_by = (d << sh) | (d >> (WIDTH - sh));
        endcase
    endfunction

`ifdef PIPE_BARREL_SHIFTER_STICKY_EN
    function automatic logic dropped_bits(input logic [WIDTH-1:0] d,
                                          input int unsigned      sh);
        logic [WIDTH-1:0] mask;
        mask = ~({WIDTH{1'b1}} << sh);
        dropped_bits = |(d & mask);
    endfunction
`endif

    logic           stall;
    logic           last_vld;
    logic [SHW-1:0] amt_in;

    // Rotate amounts at or above WIDTH fold back once; in_amt < 2*WIDTH always holds.
    always_comb begin
        amt_in = in_amt;
        if (in_mode == MODE_ROL && {1'b0, in_amt} >= AMT_WRAP) begin
            amt_in = SHW'({1'b0, in_amt} - AMT_WRAP);
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned SH  = 1 << (SHW - 1 - k);
        localparam int          BIT = SHW - 1 - k;

        logic             src_vld;
        logic [WIDTH-1:0] src_data;
        logic [1:0]       src_mode;
        logic [SHW-1:0]   src_amt;

        logic             vld_q;
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;
        logic [1:0]       mode_q;
        logic [SHW-1:0]   amt_q;

        if (k == 0) begin : g_src
            assign src_vld  = in_valid;
            assign src_data = in_data;
            assign src_mode = in_mode;
            assign src_amt  = amt_in;
        end else begin : g_src
            assign src_vld  = g_stage[k-1].vld_q;
            assign src_data = g_stage[k-1].data_q;
            assign src_mode = g_stage[k-1].mode_q;
            assign src_amt  = g_stage[k-1].amt_q;
        end

        always_comb begin
            data_d = src_data;
            if (src_amt[BIT]) begin
                data_d = shift_by(src_data, src_mode, SH);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (!stall) begin
                vld_q <= src_vld;
            end
        end

        // Datapath registers carry no reset; validity alone qualifies them.
        always_ff @(posedge clk) begin
            if (!stall) begin
                data_q <= data_d;
                mode_q <= src_mode;
                amt_q  <= src_amt;
            end
        end

`ifdef PIPE_BARREL_SHIFTER_STICKY_EN
        logic src_sticky;
        logic sticky_d;
        logic sticky_q;

        if (k == 0) begin : g_stk_src
            assign src_sticky = 1'b0;
        end else begin : g_stk_src
            assign src_sticky = g_stage[k-1].sticky_q;
        end

        always_comb begin
            sticky_d = src_sticky;
            if (src_amt[BIT] && (src_mode == MODE_SRL || src_mode == MODE_SRA)) begin
                sticky_d = src_sticky | dropped_bits(src_data, SH);
            end
        end

        always_ff @(posedge clk) begin
            if (!stall) begin
                sticky_q <= sticky_d;
            end
        end
`endif
    end

    assign last_vld  = g_stage[SHW-1].vld_q;
    assign out_valid = last_vld & ~rst;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_data  = out_valid ? g_stage[SHW-1].data_q : '0;

`ifdef PIPE_BARREL_SHIFTER_STICKY_EN
    assign out_sticky = out_valid & g_stage[SHW-1].sticky_q;
`else
    assign out_sticky = 1'b0;
`endif

    // Control carried out of the final stage has no consumer.
    logic unused_tail;
    assign unused_tail = ^{g_stage[SHW-1].mode_q, g_stage[SHW-1].amt_q};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed bench for pipe_barrel_shifter (WIDTH=25, SHW=5): single beats, stall stream, mid-flight reset.
module tb_pipe_barrel_shifter;

    localparam int WIDTH = 25;
    localparam int SHW   = 5;

`ifdef PIPE_BARREL_SHIFTER_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sticky;

    int n_checks = 0;
    int n_errors = 0;

    pipe_barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One isolated beat: latency, data and sticky.
    task automatic run_one(input string tag, input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                           input logic [1:0] m, input logic [WIDTH-1:0] exp_d, input logic exp_s);
        int lat;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_stk"}, 32'(out_sticky), 32'(exp_s));
        @(negedge clk);
    endtask

    logic [WIDTH-1:0] s_data [10] = '{25'h0000001, 25'h0000010, 25'h1000000, 25'h1000000, 25'h0000003,
                                      25'h0000100, 25'h1FFFFFF, 25'h0000005, 25'h000000F, 25'h0001234};
    logic [SHW-1:0]   s_amt  [10] = '{5'd1, 5'd2, 5'd1, 5'd1, 5'd4, 5'd8, 5'd24, 5'd26, 5'd0, 5'd4};
    logic [1:0]       s_mode [10] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [WIDTH-1:0] s_exp  [10] = '{25'h0000002, 25'h0000004, 25'h1800000, 25'h0000001, 25'h0000030,
                                      25'h0000001, 25'h1FFFFFF, 25'h000000A, 25'h000000F, 25'h0012340};

    initial begin
        int sent;
        int recv;
        int leak;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = 2'b00;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_sticky", 32'(out_sticky), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        run_one("sll2", 25'b0101111111101010111111101, 5'd2, 2'b00, 25'b0111111110101011111110100, 1'b0);
        run_one("srl3", 25'h0000007, 5'd3, 2'b01, 25'h0000000, STK);
        run_one("sra4", 25'h1000000, 5'd4, 2'b10, 25'h1F00000, 1'b0);
        run_one("sra30", 25'h1000000, 5'd30, 2'b10, 25'h1FFFFFF, STK);
        run_one("rol27", 25'h1000001, 5'd27, 2'b11, 25'h0000006, 1'b0);
        run_one("srl0", 25'h1ABCDEF, 5'd0, 2'b01, 25'h1ABCDEF, 1'b0);
        run_one("sll31", 25'h1FFFFFF, 5'd31, 2'b00, 25'h0000000, 1'b0);
        run_one("rol24", 25'h0000001, 5'd24, 2'b11, 25'h1000000, 1'b0);
        run_one("rol25", 25'h0000003, 5'd25, 2'b11, 25'h0000003, 1'b0);
        run_one("sra8pos", 25'h0FF0000, 5'd8, 2'b10, 25'h000FF00, 1'b0);
        run_one("srl8stk", 25'h0000180, 5'd8, 2'b01, 25'h0000001, STK);
        run_one("srl31", 25'h1000000, 5'd31, 2'b01, 25'h0000000, STK);

        // Continuous stream of mixed modes with out_ready low on cycles 8..10.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
            out_ready = !(cyc >= 8 && cyc <= 10);
            if (sent < 10) begin
                in_valid = 1'b1;
                in_data  = s_data[sent];
                in_amt   = s_amt[sent];
                in_mode  = s_mode[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 13) begin
                check("stream_ready", 32'(in_ready), (cyc >= 8 && cyc <= 10) ? 32'd0 : 32'd1);
            end
            if (out_valid) begin
                check("stream_data", 32'(out_data), 32'(s_exp[recv]));
                if (recv == 6) begin
                    check("stream_stk6", 32'(out_sticky), 32'(STK));
                end
                if (out_ready) recv++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'd10);
        check("stream_recv", 32'(recv), 32'd10);

        // Reset with three beats in flight.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 25'(i + 1);
            in_amt   = 5'd0;
            in_mode  = 2'b00;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready_after", 32'(in_ready), 32'd1);
        leak = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) leak++;
        end
        check("mid_rst_leak", 32'(leak), 32'd0);

        run_one("after_rst", 25'h0000009, 5'd1, 2'b01, 25'h0000004, STK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
